// File: rtl/sha2_pkg.sv
// Shared SHA-2 types and round functions.
// Word functions operate on 64-bit containers; ws selects 32- or 64-bit words.
package sha2_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    DONE
  } state_t;

  function automatic logic [63:0] rotr(
    input logic [63:0] x,
    input int          n,
    input int          ws
  );
    logic [63:0] r;
    if (ws == 32)
      r = {32'h0, (x[31:0] >> n) | (x[31:0] << (32 - n))};
    else
      r = (x >> n) | (x << (64 - n));
    return r;
  endfunction

  function automatic int s0_rot(input int ws, input int i);
    int r;
    unique case (i)
      0:       r = (ws == 32) ? 2  : 28;
      1:       r = (ws == 32) ? 13 : 34;
      default: r = (ws == 32) ? 22 : 39;
    endcase
    return r;
  endfunction

  function automatic int s1_rot(input int ws, input int i);
    int r;
    unique case (i)
      0:       r = (ws == 32) ? 6  : 14;
      1:       r = (ws == 32) ? 11 : 18;
      default: r = (ws == 32) ? 25 : 41;
    endcase
    return r;
  endfunction

  function automatic logic [63:0] bsig0(
    input logic [63:0] x,
    input int          ws
  );
    return rotr(x, s0_rot(ws, 0), ws)
         ^ rotr(x, s0_rot(ws, 1), ws)
         ^ rotr(x, s0_rot(ws, 2), ws);
  endfunction

  function automatic logic [63:0] bsig1(
    input logic [63:0] x,
    input int          ws
  );
    return rotr(x, s1_rot(ws, 0), ws)
         ^ rotr(x, s1_rot(ws, 1), ws)
         ^ rotr(x, s1_rot(ws, 2), ws);
  endfunction

  function automatic logic [63:0] ch(
    input logic [63:0] e,
    input logic [63:0] f,
    input logic [63:0] g
  );
    return (e & f) ^ (~e & g);
  endfunction

endpackage

// File: rtl/sha2_maj.sv
// Bitwise majority primitive shared by the SHA-2 datapaths.
// Each output bit is the majority of the three input bits.
module sha2_maj #(
  parameter int WORDSIZE = 32
) (
  input  logic [WORDSIZE-1:0] x,
  input  logic [WORDSIZE-1:0] y,
  input  logic [WORDSIZE-1:0] z,
  output logic [WORDSIZE-1:0] m
);

  assign m = (x & y) | (x & z) | (y & z);

endmodule

// File: rtl/sha2_round.sv
// Combinational single SHA-2 compression round.
// Maps working state a..h plus Kt+Wt to the next working state.
module sha2_round
  import sha2_pkg::*;
#(
  parameter int WORDSIZE = 32
) (
  input  logic [WORDSIZE-1:0] a,
  input  logic [WORDSIZE-1:0] b,
  input  logic [WORDSIZE-1:0] c,
  input  logic [WORDSIZE-1:0] d,
  input  logic [WORDSIZE-1:0] e,
  input  logic [WORDSIZE-1:0] f,
  input  logic [WORDSIZE-1:0] g,
  input  logic [WORDSIZE-1:0] h,
  input  logic [WORDSIZE-1:0] kw,
  output logic [WORDSIZE-1:0] na,
  output logic [WORDSIZE-1:0] nb,
  output logic [WORDSIZE-1:0] nc,
  output logic [WORDSIZE-1:0] nd,
  output logic [WORDSIZE-1:0] ne,
  output logic [WORDSIZE-1:0] nf,
  output logic [WORDSIZE-1:0] ng,
  output logic [WORDSIZE-1:0] nh
);

  localparam int W = WORDSIZE;

  logic [W-1:0] s0, s1, chv, majv, t1, t2;

  assign s0  = W'(bsig0(64'(a), W));
  assign s1  = W'(bsig1(64'(e), W));
  assign chv = W'(ch(64'(e), 64'(f), 64'(g)));

  sha2_maj #(.WORDSIZE(W)) u_maj (
    .x(a),
    .y(b),
    .z(c),
    .m(majv)
  );

  assign t1 = h + s1 + chv + kw;
  assign t2 = s0 + majv;

  assign na = t1 + t2;
  assign nb = a;
  assign nc = b;
  assign nd = c;
  assign ne = d + t1;
  assign nf = e;
  assign ng = f;
  assign nh = g;

endmodule

// File: rtl/sha2_round_engine.sv
// Iterative SHA-2 compression engine, one round per clock.
// Define SHA2_ROUND_ENGINE_STALL_CNT_EN to add the stall_cycles counter.
module sha2_round_engine
  import sha2_pkg::*;
#(
  parameter  int WORDSIZE   = 32,
  parameter  int NUM_ROUNDS = 64,
  localparam int CNT_W      = $clog2(NUM_ROUNDS + 1)
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  init_valid,
  output logic                  init_ready,
  input  logic [8*WORDSIZE-1:0] init_state,
  input  logic                  kw_valid,
  output logic                  kw_ready,
  input  logic [WORDSIZE-1:0]   kw_data,
  output logic                  out_valid,
  input  logic                  out_ready,
  output logic [8*WORDSIZE-1:0] out_state,
  output logic                  busy,
  output logic [CNT_W-1:0]      round_idx
`ifdef SHA2_ROUND_ENGINE_STALL_CNT_EN
  ,
  output logic [31:0]           stall_cycles
`endif
);

  localparam int W = WORDSIZE;

  if (!(W == 32 || W == 64)) begin : g_bad_ws
    $error("sha2_round_engine: WORDSIZE must be 32 or 64");
  end
  if (NUM_ROUNDS < 1 || NUM_ROUNDS > 127) begin : g_bad_nr
    $error("sha2_round_engine: NUM_ROUNDS must be 1..127");
  end

  state_t state, state_n;

  logic [7:0][W-1:0] hreg, wreg, nxt, sum;
  logic              init_fire, kw_fire, last;

  assign init_fire = init_ready & init_valid;
  assign kw_fire   = kw_ready & kw_valid;
  assign last      = round_idx == CNT_W'(NUM_ROUNDS - 1);

  always_ff @(posedge clk) begin
    if (!rst_n) state <= IDLE;
    else        state <= state_n;
  end

  always_comb begin
    state_n    = state;
    init_ready = 1'b0;
    kw_ready   = 1'b0;
    out_valid  = 1'b0;
    busy       = 1'b0;
    unique case (state)
      IDLE: begin
        init_ready = 1'b1;
        if (init_valid) state_n = RUN;
      end
      RUN: begin
        kw_ready = 1'b1;
        busy     = 1'b1;
        if (kw_valid && last) state_n = DONE;
      end
      DONE: begin
        out_valid = 1'b1;
        busy      = 1'b1;
        if (out_ready) state_n = IDLE;
      end
      default: state_n = IDLE;
    endcase
  end

  sha2_round #(.WORDSIZE(W)) u_round (
    .a (wreg[0]),
    .b (wreg[1]),
    .c (wreg[2]),
    .d (wreg[3]),
    .e (wreg[4]),
    .f (wreg[5]),
    .g (wreg[6]),
    .h (wreg[7]),
    .kw(kw_data),
    .na(nxt[0]),
    .nb(nxt[1]),
    .nc(nxt[2]),
    .nd(nxt[3]),
    .ne(nxt[4]),
    .nf(nxt[5]),
    .ng(nxt[6]),
    .nh(nxt[7])
  );

  // Feed-forward uses the post-round state so DONE is reached in one edge.
  always_comb begin
    for (int i = 0; i < 8; i++) sum[i] = hreg[i] + nxt[i];
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      hreg      <= '0;
      wreg      <= '0;
      out_state <= '0;
      round_idx <= '0;
    end else if (init_fire) begin
      hreg      <= init_state;
      wreg      <= init_state;
      round_idx <= '0;
    end else if (kw_fire) begin
      wreg      <= nxt;
      round_idx <= round_idx + 1'b1;
      if (last) out_state <= sum;
    end
  end

`ifdef SHA2_ROUND_ENGINE_STALL_CNT_EN
  always_ff @(posedge clk) begin
    if (!rst_n)
      stall_cycles <= '0;
    else if (init_fire)
      stall_cycles <= '0;
    else if (state == RUN && !kw_valid && stall_cycles != '1)
      stall_cycles <= stall_cycles + 32'd1;
  end
`endif

endmodule

// File: tb/tb_sha2_round_engine.sv
// Self-checking bench for sha2_round_engine (SHA-256, SHA-512, 1-round).
// Digests come from known answers or a reference compression model.
module tb_sha2_round_engine;

  localparam logic [31:0] K256 [64] = '{
    32'h428a2f98, 32'h71374491, 32'hb5c0fbcf, 32'he9b5dba5,
    32'h3956c25b, 32'h59f111f1, 32'h923f82a4, 32'hab1c5ed5,
    32'hd807aa98, 32'h12835b01, 32'h243185be, 32'h550c7dc3,
    32'h72be5d74, 32'h80deb1fe, 32'h9bdc06a7, 32'hc19bf174,
    32'he49b69c1, 32'hefbe4786, 32'h0fc19dc6, 32'h240ca1cc,
    32'h2de92c6f, 32'h4a7484aa, 32'h5cb0a9dc, 32'h76f988da,
    32'h983e5152, 32'ha831c66d, 32'hb00327c8, 32'hbf597fc7,
    32'hc6e00bf3, 32'hd5a79147, 32'h06ca6351, 32'h14292967,
    32'h27b70a85, 32'h2e1b2138, 32'h4d2c6dfc, 32'h53380d13,
    32'h650a7354, 32'h766a0abb, 32'h81c2c92e, 32'h92722c85,
    32'ha2bfe8a1, 32'ha81a664b, 32'hc24b8b70, 32'hc76c51a3,
    32'hd192e819, 32'hd6990624, 32'hf40e3585, 32'h106aa070,
    32'h19a4c116, 32'h1e376c08, 32'h2748774c, 32'h34b0bcb5,
    32'h391c0cb3, 32'h4ed8aa4a, 32'h5b9cca4f, 32'h682e6ff3,
    32'h748f82ee, 32'h78a5636f, 32'h84c87814, 32'h8cc70208,
    32'h90befffa, 32'ha4506ceb, 32'hbef9a3f7, 32'hc67178f2
  };

  localparam logic [31:0] IV256 [8] = '{
    32'h6a09e667, 32'hbb67ae85, 32'h3c6ef372, 32'ha54ff53a,
    32'h510e527f, 32'h9b05688c, 32'h1f83d9ab, 32'h5be0cd19
  };

  localparam logic [31:0] ABC256 [8] = '{
    32'hba7816bf, 32'h8f01cfea, 32'h414140de, 32'h5dae2223,
    32'hb00361a3, 32'h96177a9c, 32'hb410ff61, 32'hf20015ad
  };

  typedef struct {
    logic [255:0]  iv;
    logic [2047:0] kw;
    int            stalls;
    logic [255:0]  dig;
    int            lat;
  } vec_t;

  logic clk;
  logic rst_n;

  logic         init_valid, init_ready, kw_valid, kw_ready;
  logic         out_valid, out_ready, busy;
  logic [255:0] init_state, out_state;
  logic [31:0]  kw_data;
  logic [6:0]   round_idx;

  logic         e_init_valid, e_init_ready, e_kw_valid, e_kw_ready;
  logic         e_out_valid, e_out_ready, e_busy;
  logic [511:0] e_init_state, e_out_state;
  logic [63:0]  e_kw_data;
  logic [6:0]   e_round_idx;

  logic         m_init_valid, m_init_ready, m_kw_valid, m_kw_ready;
  logic         m_out_valid, m_out_ready, m_busy;
  logic [255:0] m_init_state, m_out_state;
  logic [31:0]  m_kw_data;
  logic [0:0]   m_round_idx;

`ifdef SHA2_ROUND_ENGINE_STALL_CNT_EN
  logic [31:0] stall_cycles, e_stall_cycles, m_stall_cycles;
`endif

  int passed = 0;
  int total  = 0;

  longint unsigned m_iv [8];
  longint unsigned m_kw [80];
  longint unsigned m_dig [8];

  vec_t tbl [5];

  sha2_round_engine #(.WORDSIZE(32), .NUM_ROUNDS(64)) u_d (
    .clk(clk), .rst_n(rst_n),
    .init_valid(init_valid), .init_ready(init_ready),
    .init_state(init_state),
    .kw_valid(kw_valid), .kw_ready(kw_ready), .kw_data(kw_data),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_state(out_state), .busy(busy), .round_idx(round_idx)
`ifdef SHA2_ROUND_ENGINE_STALL_CNT_EN
    , .stall_cycles(stall_cycles)
`endif
  );

  sha2_round_engine #(.WORDSIZE(64), .NUM_ROUNDS(80)) u_e (
    .clk(clk), .rst_n(rst_n),
    .init_valid(e_init_valid), .init_ready(e_init_ready),
    .init_state(e_init_state),
    .kw_valid(e_kw_valid), .kw_ready(e_kw_ready), .kw_data(e_kw_data),
    .out_valid(e_out_valid), .out_ready(e_out_ready),
    .out_state(e_out_state), .busy(e_busy), .round_idx(e_round_idx)
`ifdef SHA2_ROUND_ENGINE_STALL_CNT_EN
    , .stall_cycles(e_stall_cycles)
`endif
  );

  sha2_round_engine #(.WORDSIZE(32), .NUM_ROUNDS(1)) u_m (
    .clk(clk), .rst_n(rst_n),
    .init_valid(m_init_valid), .init_ready(m_init_ready),
    .init_state(m_init_state),
    .kw_valid(m_kw_valid), .kw_ready(m_kw_ready), .kw_data(m_kw_data),
    .out_valid(m_out_valid), .out_ready(m_out_ready),
    .out_state(m_out_state), .busy(m_busy), .round_idx(m_round_idx)
`ifdef SHA2_ROUND_ENGINE_STALL_CNT_EN
    , .stall_cycles(m_stall_cycles)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic chk(input string nm, input logic [511:0] act,
                     input logic [511:0] exp);
    total++;
    if (act === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h", nm, act, exp);
  endtask

  function automatic logic [31:0] ror32(input logic [31:0] x, input int n);
    return (x >> n) | (x << (32 - n));
  endfunction

  function automatic longint unsigned msk(input int ws);
    return (ws == 32) ? 64'h0000_0000_ffff_ffff : 64'hffff_ffff_ffff_ffff;
  endfunction

  function automatic longint unsigned rr(input longint unsigned x,
                                         input int n, input int ws);
    return ((x >> n) | (x << (ws - n))) & msk(ws);
  endfunction

  // Reference: textbook compression over a shifting array of 8 words.
  task automatic ref_compress(input int ws, input int nr);
    longint unsigned v [8];
    longint unsigned t1, t2, s0, s1, chv, mj, m;
    m = msk(ws);
    for (int i = 0; i < 8; i++) v[i] = m_iv[i];
    for (int t = 0; t < nr; t++) begin
      if (ws == 32) begin
        s0 = rr(v[0], 2, 32) ^ rr(v[0], 13, 32) ^ rr(v[0], 22, 32);
        s1 = rr(v[4], 6, 32) ^ rr(v[4], 11, 32) ^ rr(v[4], 25, 32);
      end else begin
        s0 = rr(v[0], 28, 64) ^ rr(v[0], 34, 64) ^ rr(v[0], 39, 64);
        s1 = rr(v[4], 14, 64) ^ rr(v[4], 18, 64) ^ rr(v[4], 41, 64);
      end
      chv = (v[4] & v[5]) ^ (~v[4] & v[6] & m);
      mj  = (v[0] & v[1]) ^ (v[0] & v[2]) ^ (v[1] & v[2]);
      t1  = (v[7] + s1 + chv + m_kw[t]) & m;
      t2  = (s0 + mj) & m;
      for (int i = 7; i > 0; i--) v[i] = v[i-1];
      v[4] = (v[4] + t1) & m;
      v[0] = (t1 + t2) & m;
    end
    for (int i = 0; i < 8; i++) m_dig[i] = (m_iv[i] + v[i]) & m;
  endtask

  function automatic logic [2047:0] abc_kw();
    logic [31:0]   w [64];
    logic [31:0]   s0, s1;
    logic [2047:0] r;
    for (int t = 0; t < 16; t++) w[t] = 32'h0;
    w[0]  = 32'h61626380;
    w[15] = 32'h00000018;
    for (int t = 16; t < 64; t++) begin
      s0 = ror32(w[t-15], 7) ^ ror32(w[t-15], 18) ^ (w[t-15] >> 3);
      s1 = ror32(w[t-2], 17) ^ ror32(w[t-2], 19) ^ (w[t-2] >> 10);
      w[t] = w[t-16] + s0 + w[t-7] + s1;
    end
    for (int t = 0; t < 64; t++) r[t*32 +: 32] = w[t] + K256[t];
    return r;
  endfunction

  task automatic run32(input vec_t r, input bit bp);
    int k, s, cyc, w;
    logic [255:0] held;
    @(negedge clk);
    chk("idle_init_ready", 512'(init_ready), 512'(1));
    init_state = r.iv;
    init_valid = 1'b1;
    cyc = 0;
    k = 0;
    s = r.stalls;
    @(negedge clk);
    cyc++;
    init_valid = 1'b0;
    chk("run_busy", 512'(busy), 512'(1));
    chk("run_kw_ready", 512'(kw_ready), 512'(1));
    chk("run_idx_clear", 512'(round_idx), 512'(0));
    while (k < 64) begin
      if (k == 63 && s == 0)
        chk("no_early_out", 512'(out_valid), 512'(0));
      if (s > 0 && ($urandom_range(0, 3) == 0 || k == 63)) begin
        kw_valid = 1'b0;
        kw_data  = $urandom;
        s--;
      end else begin
        kw_valid = 1'b1;
        kw_data  = r.kw[k*32 +: 32];
        k++;
      end
      @(negedge clk);
      cyc++;
    end
    kw_valid = 1'b0;
    w = 0;
    while (!out_valid && w < 8) begin
      @(negedge clk);
      cyc++;
      w++;
    end
    chk("out_latency", 512'(cyc), 512'(r.lat));
    chk("digest", 512'(out_state), 512'(r.dig));
    chk("done_idx", 512'(round_idx), 512'(64));
    chk("done_kw_ready", 512'(kw_ready), 512'(0));
    chk("done_init_ready", 512'(init_ready), 512'(0));
`ifdef SHA2_ROUND_ENGINE_STALL_CNT_EN
    chk("stall_cycles", 512'(stall_cycles), 512'(r.stalls));
`endif
    if (bp) begin
      held = out_state;
      init_valid = 1'b1;
      init_state = ~r.iv;
      repeat (5) begin
        @(negedge clk);
        chk("bp_valid", 512'(out_valid), 512'(1));
        chk("bp_state", 512'(out_state), 512'(held));
        chk("bp_init_ready", 512'(init_ready), 512'(0));
      end
      init_valid = 1'b0;
    end
    out_ready = 1'b1;
    @(negedge clk);
    out_ready = 1'b0;
    chk("idle_after_out", 512'(init_ready), 512'(1));
    chk("out_valid_drop", 512'(out_valid), 512'(0));
    chk("idle_busy", 512'(busy), 512'(0));
    chk("out_state_kept", 512'(out_state), 512'(r.dig));
    if (bp) chk("idle_idx_held", 512'(round_idx), 512'(64));
  endtask

  initial begin
    logic [255:0] iv_abc, dig_abc;
    logic [2047:0] kw_abc;
    int cyc, st;

    rst_n = 1'b0;
    init_valid = 1'b0; kw_valid = 1'b0; out_ready = 1'b0;
    init_state = '0; kw_data = '0;
    e_init_valid = 1'b0; e_kw_valid = 1'b0; e_out_ready = 1'b0;
    e_init_state = '0; e_kw_data = '0;
    m_init_valid = 1'b0; m_kw_valid = 1'b0; m_out_ready = 1'b0;
    m_init_state = '0; m_kw_data = '0;

    for (int i = 0; i < 8; i++) begin
      iv_abc[i*32 +: 32]  = IV256[i];
      dig_abc[i*32 +: 32] = ABC256[i];
    end
    kw_abc = abc_kw();

    repeat (2) @(negedge clk);
    chk("rst_init_ready", 512'(init_ready), 512'(1));
    chk("rst_kw_ready", 512'(kw_ready), 512'(0));
    chk("rst_out_valid", 512'(out_valid), 512'(0));
    chk("rst_busy", 512'(busy), 512'(0));
    chk("rst_idx", 512'(round_idx), 512'(0));
    chk("rst_out_state", 512'(out_state), 512'(0));
    rst_n = 1'b1;

    @(negedge clk);
    kw_valid = 1'b1;
    kw_data  = 32'hdeadbeef;
    @(negedge clk);
    kw_valid = 1'b0;
    chk("idle_kw_ignored_idx", 512'(round_idx), 512'(0));
    chk("idle_kw_ignored_busy", 512'(busy), 512'(0));

    tbl[0] = '{iv: iv_abc, kw: kw_abc, stalls: 0, dig: dig_abc, lat: 65};
    tbl[1] = '{iv: iv_abc, kw: kw_abc, stalls: 20, dig: dig_abc, lat: 85};
    for (int n = 2; n < 5; n++) begin
      for (int i = 0; i < 8; i++) begin
        tbl[n].iv[i*32 +: 32] = $urandom;
        m_iv[i] = 64'(tbl[n].iv[i*32 +: 32]);
      end
      for (int t = 0; t < 64; t++) begin
        tbl[n].kw[t*32 +: 32] = $urandom;
        m_kw[t] = 64'(tbl[n].kw[t*32 +: 32]);
      end
      ref_compress(32, 64);
      for (int i = 0; i < 8; i++) tbl[n].dig[i*32 +: 32] = m_dig[i][31:0];
      tbl[n].stalls = $urandom_range(0, 8);
      tbl[n].lat    = 65 + tbl[n].stalls;
    end

    for (int n = 0; n < 5; n++) run32(tbl[n], n == 2);

    // SHA-512 width with random words and a few stalls.
    for (int i = 0; i < 8; i++) begin
      e_init_state[i*64 +: 64] = {$urandom, $urandom};
      m_iv[i] = e_init_state[i*64 +: 64];
    end
    for (int t = 0; t < 80; t++) m_kw[t] = {$urandom, $urandom};
    ref_compress(64, 80);
    @(negedge clk);
    e_init_valid = 1'b1;
    @(negedge clk);
    e_init_valid = 1'b0;
    cyc = 1;
    st = 0;
    for (int t = 0; t < 80; t++) begin
      if ($urandom_range(0, 9) == 0) begin
        e_kw_valid = 1'b0;
        e_kw_data  = {$urandom, $urandom};
        st++;
        @(negedge clk);
        cyc++;
      end
      e_kw_valid = 1'b1;
      e_kw_data  = m_kw[t];
      @(negedge clk);
      cyc++;
    end
    e_kw_valid = 1'b0;
    chk("e_latency_valid", 512'(e_out_valid), 512'(1));
    chk("e_latency_cycle", 512'(cyc), 512'(81 + st));
    for (int i = 0; i < 8; i++)
      chk("e_digest_word", 512'(e_out_state[i*64 +: 64]), 512'(m_dig[i]));
    chk("e_done_idx", 512'(e_round_idx), 512'(80));
`ifdef SHA2_ROUND_ENGINE_STALL_CNT_EN
    chk("e_stall_cycles", 512'(e_stall_cycles), 512'(st));
`endif
    e_out_ready = 1'b1;
    @(negedge clk);
    e_out_ready = 1'b0;
    chk("e_idle", 512'(e_init_ready), 512'(1));
    chk("e_busy", 512'(e_busy), 512'(0));

    // Single-round engine: zero state, Kt+Wt = 1.
    @(negedge clk);
    m_init_state = '0;
    m_init_valid = 1'b1;
    @(negedge clk);
    m_init_valid = 1'b0;
    chk("m_kw_ready", 512'(m_kw_ready), 512'(1));
    m_kw_valid = 1'b1;
    m_kw_data  = 32'h1;
    @(negedge clk);
    m_kw_valid = 1'b0;
    chk("m_out_valid", 512'(m_out_valid), 512'(1));
    chk("m_digest", 512'(m_out_state),
        512'((256'h1 << 128) | 256'h1));
    chk("m_idx", 512'(m_round_idx), 512'(1));
    m_out_ready = 1'b1;
    @(negedge clk);
    m_out_ready = 1'b0;
    chk("m_idle", 512'(m_init_ready), 512'(1));

    // Reset in the middle of a block, then a fresh block.
    @(negedge clk);
    init_state = iv_abc;
    init_valid = 1'b1;
    @(negedge clk);
    init_valid = 1'b0;
    for (int t = 0; t < 30; t++) begin
      kw_valid = 1'b1;
      kw_data  = kw_abc[t*32 +: 32];
      @(negedge clk);
    end
    chk("mid_idx30", 512'(round_idx), 512'(30));
    rst_n = 1'b0;
    kw_data = $urandom;
    @(negedge clk);
    rst_n = 1'b1;
    kw_valid = 1'b0;
    chk("mid_rst_init_ready", 512'(init_ready), 512'(1));
    chk("mid_rst_busy", 512'(busy), 512'(0));
    chk("mid_rst_out_valid", 512'(out_valid), 512'(0));
    chk("mid_rst_idx", 512'(round_idx), 512'(0));
    chk("mid_rst_out_state", 512'(out_state), 512'(0));
    run32(tbl[0], 1'b0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule
